// File: rtl/line_job_sched.sv
// line_job_sched: queues line-segment draw requests in a small FIFO and issues
// them one at a time to a shared Bresenham line engine over a start/done
// handshake, with flush, per-line watchdog abort and status counters.
module line_job_sched #(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [10:0]                req_x0,
  input  logic [9:0]                 req_y0,
  input  logic [10:0]                req_x1,
  input  logic [9:0]                 req_y1,
  input  logic                       enable,
  input  logic                       flush,
  output logic                       eng_start,
  output logic [10:0]                eng_x0,
  output logic [9:0]                 eng_y0,
  output logic [10:0]                eng_x1,
  output logic [9:0]                 eng_y1,
  input  logic                       eng_done,
  output logic                       eng_abort,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     queue_count,
  output logic [CNT_W-1:0]           lines_done,
  output logic                       err_timeout,
  input  logic                       clear_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // Last wait-counter value before the watchdog fires (counter starts at 0).
  localparam int TLIM = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  logic [41:0]       mem [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  state_e            state_q, state_d;
  logic [TW-1:0]     wcnt_q, wcnt_d;
  logic              eng_start_q, eng_start_d;
  logic              eng_abort_q, eng_abort_d;
  logic [41:0]       coord_q, coord_d;
  logic [CNT_W-1:0]  lines_q, lines_d;
  logic              err_q, err_d;

  logic full, empty, push, pop;
  logic [41:0] head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // A launch pops the head; flush suppresses both the pop and the launch.
  assign pop   = (state_q == S_IDLE) && enable && !empty && !flush;
  // A same-cycle pop frees a slot, so a push is taken even while full.
  assign push  = req_valid && (!full || pop) && !flush;
  assign head  = mem[rptr_q];

  // Storage write; entries are packed {x0, y0, x1, y1}.
  // NOTE: the payload array has no reset -- validity is tracked by the pointers
  // and count alone, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {req_x0, req_y0, req_x1, req_y1};
  end

  // FIFO pointer and occupancy next-state; flush wins over push and pop.
  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Launch/wait state machine with watchdog; eng_done beats a same-edge timeout.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    eng_start_d = 1'b0;
    eng_abort_d = 1'b0;
    coord_d     = coord_q;
    lines_d     = lines_q;
    err_d       = clear_err ? 1'b0 : err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          coord_d     = head;
          eng_start_d = 1'b1;
          wcnt_d      = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          lines_d = lines_q + 1'b1;
          state_d = S_IDLE;
        end else if (TIMEOUT_CYC != 0 && wcnt_q == TW'(TLIM)) begin
          eng_abort_d = 1'b1;
          err_d       = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All control state and registered outputs; reset drops any in-flight job.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      eng_start_q <= 1'b0;
      eng_abort_q <= 1'b0;
      coord_q     <= '0;
      lines_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      eng_start_q <= eng_start_d;
      eng_abort_q <= eng_abort_d;
      coord_q     <= coord_d;
      lines_q     <= lines_d;
      err_q       <= err_d;
    end
  end

  assign req_ready   = !full;
  assign busy        = (state_q == S_WAIT) || !empty;
  assign queue_count = count_q;
  assign eng_start   = eng_start_q;
  assign eng_abort   = eng_abort_q;
  assign {eng_x0, eng_y0, eng_x1, eng_y1} = coord_q;
  assign lines_done  = lines_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_line_job_sched.sv
// Testbench for line_job_sched: a vector table, hand-written corner-case
// sequences, and a randomized run against a queue-level reference model.
// A second instance with a short watchdog exercises the timeout path.
module tb_line_job_sched;

  logic        clk = 1'b0;
  logic        reset, req_valid, enable, flush, eng_done, clear_err;
  logic [10:0] req_x0, req_x1;
  logic [9:0]  req_y0, req_y1;

  logic        req_ready, eng_start, eng_abort, busy, err_timeout;
  logic [10:0] eng_x0, eng_x1;
  logic [9:0]  eng_y0, eng_y1;
  logic [4:0]  queue_count;
  logic [15:0] lines_done;

  logic        w_req_ready, w_eng_start, w_eng_abort, w_busy, w_err_timeout;
  logic [10:0] w_eng_x0, w_eng_x1;
  logic [9:0]  w_eng_y0, w_eng_y1;
  logic [4:0]  w_queue_count;
  logic [15:0] w_lines_done;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  line_job_sched #(.DEPTH(16), .TIMEOUT_CYC(1048576), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .enable(enable), .flush(flush), .eng_start(eng_start),
    .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1),
    .eng_done(eng_done), .eng_abort(eng_abort), .busy(busy),
    .queue_count(queue_count), .lines_done(lines_done),
    .err_timeout(err_timeout), .clear_err(clear_err)
  );

  line_job_sched #(.DEPTH(16), .TIMEOUT_CYC(8), .CNT_W(16)) dut_wd (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(w_req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .enable(enable), .flush(flush), .eng_start(w_eng_start),
    .eng_x0(w_eng_x0), .eng_y0(w_eng_y0), .eng_x1(w_eng_x1), .eng_y1(w_eng_y1),
    .eng_done(eng_done), .eng_abort(w_eng_abort), .busy(w_busy),
    .queue_count(w_queue_count), .lines_done(w_lines_done),
    .err_timeout(w_err_timeout), .clear_err(clear_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; enable = 0; flush = 0; eng_done = 0; clear_err = 0;
    req_x0 = 0; req_y0 = 0; req_x1 = 0; req_y1 = 0;
  endtask

  task automatic drive_req(input int x0, input int y0, input int x1, input int y1);
    req_valid = 1;
    req_x0 = 11'(x0); req_y0 = 10'(y0); req_x1 = 11'(x1); req_y1 = 10'(y1);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  typedef struct {
    logic v; int x0, y0, x1, y1; logic en, fl, dn;
    logic e_start; int e_qc, e_ld; logic e_busy; int e_ex0;
  } vec_t;

  vec_t vecs[11];

  // Reference model: the FIFO is a queue of packed coordinate words.
  logic [41:0] mq[$];
  bit          m_fly;
  int          m_ld;
  logic [41:0] m_cur;
  bit          m_start;

  task automatic model_cycle();
    bit pop, push;
    logic [41:0] word;
    word = {req_x0, req_y0, req_x1, req_y1};
    pop  = !m_fly && enable && (mq.size() > 0) && !flush;
    push = req_valid && ((mq.size() < 16) || pop) && !flush;
    if (m_fly && eng_done) begin
      m_ld  = (m_ld + 1) % 65536;
      m_fly = 0;
    end
    if (flush) mq.delete();
    else begin
      if (pop) begin m_cur = mq.pop_front(); m_fly = 1; end
      if (push) mq.push_back(word);
    end
    m_start = pop;
  endtask

  int          launched[$];
  int          exp_order[$];
  int          d, aborts;

  initial begin
    vecs[0]  = '{1, 1, 2, 3, 4, 0, 0, 0,  0, 1, 0, 1, 0};
    vecs[1]  = '{1, 5, 5, 5, 5, 0, 0, 0,  0, 2, 0, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 1,  0, 2, 0, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 1, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 1};
    vecs[5]  = '{0, 0, 0, 0, 0, 1, 0, 1,  0, 1, 1, 1, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 1, 5};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 2, 0, 5};
    vecs[8]  = '{1, 7, 0, 0, 0, 0, 0, 0,  0, 1, 2, 1, 5};
    vecs[9]  = '{1, 9, 1, 1, 1, 1, 1, 0,  0, 0, 2, 0, 5};
    vecs[10] = '{0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 2, 0, 5};

    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;

    // Reset state
    check("rst_qc", queue_count, 0);
    check("rst_ready", req_ready, 1);
    check("rst_start", eng_start, 0);
    check("rst_abort", eng_abort, 0);
    check("rst_err", err_timeout, 0);
    check("rst_lines", lines_done, 0);
    check("rst_busy", busy, 0);
    check("rst_coords", {eng_x0, eng_y0, eng_x1, eng_y1}, 0);

    // Vector table: done ignored in IDLE, enable gating, degenerate line, flush priority
    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      if (vecs[i].v) drive_req(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1);
      enable = vecs[i].en; flush = vecs[i].fl; eng_done = vecs[i].dn;
      step();
      check($sformatf("vec%0d_start", i), eng_start, vecs[i].e_start);
      check($sformatf("vec%0d_qc", i), queue_count, vecs[i].e_qc);
      check($sformatf("vec%0d_lines", i), lines_done, vecs[i].e_ld);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d_x0", i), eng_x0, vecs[i].e_ex0);
    end

    // Single line: latency, coordinates, 90-cycle completion
    do_reset();
    enable = 1;
    drive_req(10, 20, 100, 50);
    step();
    req_valid = 0;
    check("a_no_early_start", eng_start, 0);
    step();
    check("a_start", eng_start, 1);
    check("a_coords", {eng_x0, eng_y0, eng_x1, eng_y1}, {11'd10, 10'd20, 11'd100, 10'd50});
    step();
    check("a_start_one_cycle", eng_start, 0);
    repeat (88) step();
    check("a_busy_wait", busy, 1);
    eng_done = 1;
    step();
    eng_done = 0;
    check("a_lines", lines_done, 1);
    check("a_busy_done", busy, 0);
    check("a_coords_held", eng_x0, 10);

    // Fill to 16 with enable low, hold off a 17th, then drain in order,
    // including a push accepted while full on the same edge as a pop
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_req(i * 100 + 7, i * 30, i * 50, i * 20 + 1);
      exp_order.push_back(i * 100 + 7);
      step();
    end
    req_valid = 0;
    check("b_qc_full", queue_count, 16);
    check("b_ready_full", req_ready, 0);
    drive_req(999, 1, 1, 1);
    step();
    req_valid = 0;
    check("b_held_off", queue_count, 16);
    enable = 1;
    step();
    check("b_first_start", eng_start, 1);
    check("b_first_x0", eng_x0, 7);
    check("b_qc_15", queue_count, 15);
    launched.push_back(int'(eng_x0));
    drive_req(1900, 2, 3, 4);
    exp_order.push_back(1900);
    step();
    req_valid = 0;
    check("b_refill", queue_count, 16);
    check("b_refill_ready", req_ready, 0);
    eng_done = 1;
    step();
    eng_done = 0;
    check("b_done1", lines_done, 1);
    drive_req(1950, 5, 6, 7);
    exp_order.push_back(1950);
    step();
    req_valid = 0;
    check("b_push_pop_full_qc", queue_count, 16);
    check("b_push_pop_start", eng_start, 1);
    launched.push_back(int'(eng_x0));
    d = 5;
    for (int c = 0; c < 400 && lines_done != 16'd18; c++) begin
      eng_done = (d == 1);
      step();
      eng_done = 0;
      if (d > 0) d--;
      if (eng_start) begin
        launched.push_back(int'(eng_x0));
        d = 5;
      end
    end
    check("b_lines_18", lines_done, 18);
    check("b_launch_count", launched.size(), 18);
    for (int i = 0; i < 18 && i < launched.size(); i++)
      check($sformatf("b_order%0d", i), launched[i], exp_order[i]);
    check("b_busy_end", busy, 0);

    // Flush with one in flight and three queued
    do_reset();
    enable = 1;
    for (int i = 0; i < 4; i++) begin
      drive_req(i + 40, 0, 0, 0);
      step();
    end
    req_valid = 0;
    check("c_qc_3", queue_count, 3);
    flush = 1;
    step();
    flush = 0;
    check("c_flush_qc", queue_count, 0);
    check("c_flush_busy_inflight", busy, 1);
    eng_done = 1;
    step();
    eng_done = 0;
    check("c_lines", lines_done, 1);
    aborts = 0;
    repeat (6) begin step(); if (eng_start) aborts++; end
    check("c_no_start_after_flush", aborts, 0);
    check("c_busy_idle", busy, 0);

    // Watchdog on the TIMEOUT_CYC=8 instance
    do_reset();
    enable = 1;
    drive_req(11, 0, 0, 0);
    step();
    drive_req(22, 0, 0, 0);
    step();
    req_valid = 0;
    check("wd_start1", w_eng_start, 1);
    check("wd_x0_1", w_eng_x0, 11);
    aborts = 0;
    repeat (7) begin step(); if (w_eng_abort) aborts++; end
    check("wd_no_early_abort", aborts, 0);
    clear_err = 1;
    step();
    clear_err = 0;
    check("wd_abort", w_eng_abort, 1);
    check("wd_err_set_wins", w_err_timeout, 1);
    check("wd_lines_unchanged", w_lines_done, 0);
    step();
    check("wd_abort_one_cycle", w_eng_abort, 0);
    check("wd_next_launch", w_eng_start, 1);
    check("wd_x0_2", w_eng_x0, 22);
    check("wd_err_sticky", w_err_timeout, 1);
    clear_err = 1;
    step();
    clear_err = 0;
    check("wd_err_cleared", w_err_timeout, 0);
    repeat (6) step();
    eng_done = 1;
    step();
    eng_done = 0;
    check("wd_done_beats_timeout", w_lines_done, 1);
    check("wd_no_abort_on_done", w_eng_abort, 0);
    check("wd_err_stays_clear", w_err_timeout, 0);

    // Reset in WAIT with four entries queued
    do_reset();
    enable = 1;
    for (int i = 0; i < 5; i++) begin
      drive_req(i + 300, 9, 9, 9);
      step();
    end
    req_valid = 0;
    check("r_qc_4", queue_count, 4);
    reset = 1;
    step();
    reset = 0;
    check("r_qc", queue_count, 0);
    check("r_abort", eng_abort, 0);
    check("r_coords", {eng_x0, eng_y0, eng_x1, eng_y1}, 0);
    check("r_ready", req_ready, 1);
    check("r_busy", busy, 0);

    // Randomized run against the reference model
    do_reset();
    mq.delete(); m_fly = 0; m_ld = 0; m_cur = '0; m_start = 0;
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_x0 = 11'($urandom); req_y0 = 10'($urandom);
      req_x1 = 11'($urandom); req_y1 = 10'($urandom);
      enable = (c % 400 < 150) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 90);
      flush = ($urandom_range(0, 99) < 3);
      eng_done = m_fly ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      model_cycle();
      step();
      check("rnd_start", eng_start, m_start);
      check("rnd_qc", queue_count, mq.size());
      check("rnd_ready", req_ready, mq.size() < 16);
      check("rnd_lines", lines_done, m_ld);
      check("rnd_busy", busy, m_fly || (mq.size() > 0));
      check("rnd_coords", {eng_x0, eng_y0, eng_x1, eng_y1}, m_cur);
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
